// File: rtl/vmem_pkg.sv
// Shared types and constants for the vector memory sequencer.
// The optional VSEQ_STRIDE_EN build uses STRIDE_W for the programmable stride port.
package vmem_pkg;

   localparam int unsigned STRIDE_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      S_ACC = 2'd1,
      V_ACC = 2'd2
   } state_e;

   typedef enum logic {
      GNT_S = 1'b0,
      GNT_V = 1'b1
   } gnt_e;

endpackage

// File: rtl/lane_addr_gen.sv
// Lane address accumulator: loads a base address, then adds the stride once per lane.
// Sums wrap modulo 2^A; clearing parks the address at zero between accesses.
module lane_addr_gen #(
   parameter int unsigned A = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic         step_i,
   input  logic         clr_i,
   input  logic [A-1:0] base_i,
   input  logic [A-1:0] stride_i,
   output logic [A-1:0] addr_o
);

   logic [A-1:0] addr_q, addr_d;

   // Load wins over step, step wins over clear.
   always_comb begin
      addr_d = addr_q;
      if (load_i) begin
         addr_d = base_i;
      end else if (step_i) begin
         addr_d = addr_q + stride_i;
      end else if (clr_i) begin
         addr_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= '0;
      end else begin
         addr_q <= addr_d;
      end
   end

   assign addr_o = addr_q;

endmodule

// File: rtl/vector_mem_sequencer.sv
// Arbitrates scalar and vector requests onto a single-port data memory.
// Define VSEQ_STRIDE_EN to add the signed 16-bit v_stride_i port; otherwise stride is +1.
module vector_mem_sequencer
   import vmem_pkg::*;
#(
   parameter int unsigned L     = 8,
   parameter int unsigned LANES = 8,
   parameter int unsigned A     = 32
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 s_req_i,
   input  logic                 s_we_i,
   input  logic [A-1:0]         s_addr_i,
   input  logic [L-1:0]         s_wdata_i,
   output logic                 s_ack_o,
   output logic [L-1:0]         s_rdata_o,
   input  logic                 v_req_i,
   input  logic                 v_we_i,
   input  logic [A-1:0]         v_addr_i,
`ifdef VSEQ_STRIDE_EN
   input  logic [STRIDE_W-1:0]  v_stride_i,
`endif
   input  logic [LANES*L-1:0]   v_wdata_i,
   output logic                 v_done_o,
   output logic                 v_busy_o,
   output logic [LANES*L-1:0]   v_rdata_o,
   output logic [A-1:0]         mem_addr_o,
   output logic [L-1:0]         mem_wdata_o,
   output logic                 mem_wren_o,
   input  logic [L-1:0]         mem_rdata_i
);

   localparam int unsigned      LW        = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [LW-1:0]    LAST_LANE = LW'(LANES - 1);

   state_e                      state_q, state_d;
   gnt_e                        last_q, last_d;
   logic [LW-1:0]               lane_q, lane_d;
   logic [LW-1:0]               lane_nxt;
   logic [LANES-1:0][L-1:0]     wdata_q, wdata_d;
   logic                        s_ack_q, s_ack_d;
   logic [L-1:0]                s_rdata_q, s_rdata_d;
   logic                        v_done_q, v_done_d;
   logic                        v_busy_q, v_busy_d;
   logic [LANES-1:0][L-1:0]     v_rdata_q, v_rdata_d;
   logic [L-1:0]                mem_wdata_q, mem_wdata_d;
   logic                        mem_wren_q, mem_wren_d;

   logic                        grant_s, grant_v;
   logic                        gen_load, gen_step, gen_clr;
   logic [A-1:0]                gen_base;
   logic [A-1:0]                stride;
   logic [A-1:0]                gen_addr;

`ifdef VSEQ_STRIDE_EN
   logic [A-1:0]                stride_q, stride_d;
   assign stride = stride_q;
`else
   assign stride = A'(1);
`endif

   // Next-state, grant and datapath control.
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      lane_d      = lane_q;
      wdata_d     = wdata_q;
      s_ack_d     = 1'b0;
      s_rdata_d   = s_rdata_q;
      v_done_d    = 1'b0;
      v_busy_d    = v_busy_q;
      v_rdata_d   = v_rdata_q;
      mem_wdata_d = mem_wdata_q;
      mem_wren_d  = mem_wren_q;
      gen_load    = 1'b0;
      gen_step    = 1'b0;
      gen_clr     = 1'b0;
      gen_base    = s_addr_i;
      grant_s     = 1'b0;
      grant_v     = 1'b0;
      lane_nxt    = lane_q + LW'(1);
`ifdef VSEQ_STRIDE_EN
      stride_d    = stride_q;
`endif

      unique case (state_q)
         IDLE: begin
            // No grant during a completion pulse so a held request is not served twice.
            if (!s_ack_q && !v_done_q) begin
               grant_s = s_req_i && (!v_req_i || (last_q == GNT_V));
               grant_v = v_req_i && !grant_s;
            end
            lane_d = '0;
            if (grant_s) begin
               state_d     = S_ACC;
               last_d      = GNT_S;
               gen_load    = 1'b1;
               gen_base    = s_addr_i;
               mem_wren_d  = s_we_i;
               mem_wdata_d = s_wdata_i;
            end else if (grant_v) begin
               state_d     = V_ACC;
               last_d      = GNT_V;
               gen_load    = 1'b1;
               gen_base    = v_addr_i;
               mem_wren_d  = v_we_i;
               wdata_d     = v_wdata_i;
               mem_wdata_d = v_wdata_i[L-1:0];
               v_busy_d    = 1'b1;
`ifdef VSEQ_STRIDE_EN
               stride_d    = A'($signed(v_stride_i));
`endif
            end
         end

         S_ACC: begin
            if (!mem_wren_q) begin
               s_rdata_d = mem_rdata_i;
            end
            s_ack_d     = 1'b1;
            state_d     = IDLE;
            mem_wren_d  = 1'b0;
            mem_wdata_d = '0;
            gen_clr     = 1'b1;
         end

         V_ACC: begin
            if (!mem_wren_q) begin
               v_rdata_d[lane_q] = mem_rdata_i;
            end
            if (lane_q == LAST_LANE) begin
               state_d     = IDLE;
               v_done_d    = 1'b1;
               v_busy_d    = 1'b0;
               mem_wren_d  = 1'b0;
               mem_wdata_d = '0;
               gen_clr     = 1'b1;
               lane_d      = '0;
            end else begin
               lane_d      = lane_nxt;
               gen_step    = 1'b1;
               mem_wdata_d = wdata_q[lane_nxt];
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= IDLE;
         last_q      <= GNT_V;
         lane_q      <= '0;
         wdata_q     <= '0;
         s_ack_q     <= 1'b0;
         s_rdata_q   <= '0;
         v_done_q    <= 1'b0;
         v_busy_q    <= 1'b0;
         v_rdata_q   <= '0;
         mem_wdata_q <= '0;
         mem_wren_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         lane_q      <= lane_d;
         wdata_q     <= wdata_d;
         s_ack_q     <= s_ack_d;
         s_rdata_q   <= s_rdata_d;
         v_done_q    <= v_done_d;
         v_busy_q    <= v_busy_d;
         v_rdata_q   <= v_rdata_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wren_q  <= mem_wren_d;
      end
   end

`ifdef VSEQ_STRIDE_EN
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         stride_q <= '0;
      end else begin
         stride_q <= stride_d;
      end
   end
`endif

   lane_addr_gen #(
      .A (A)
   ) u_lane_addr_gen (
      .clk      (CLK),
      .rst_n    (RST),
      .load_i   (gen_load),
      .step_i   (gen_step),
      .clr_i    (gen_clr),
      .base_i   (gen_base),
      .stride_i (stride),
      .addr_o   (gen_addr)
   );

   assign s_ack_o     = s_ack_q;
   assign s_rdata_o   = s_rdata_q;
   assign v_done_o    = v_done_q;
   assign v_busy_o    = v_busy_q;
   assign v_rdata_o   = v_rdata_q;
   assign mem_addr_o  = gen_addr;
   assign mem_wdata_o = mem_wdata_q;
   assign mem_wren_o  = mem_wren_q;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Self-checking bench: transaction table with per-access scoreboard, plus arbitration,
// mid-burst reset and (with VSEQ_STRIDE_EN) negative-stride sequences.
module tb_vector_mem_sequencer;

   localparam int unsigned L     = 8;
   localparam int unsigned LANES = 8;
   localparam int unsigned A     = 32;

   logic              CLK;
   logic              RST;
   logic              s_req, s_we;
   logic [A-1:0]      s_addr;
   logic [L-1:0]      s_wdata;
   logic              s_ack;
   logic [L-1:0]      s_rdata;
   logic              v_req, v_we;
   logic [A-1:0]      v_addr;
   logic [LANES*L-1:0] v_wdata;
   logic              v_done, v_busy;
   logic [LANES*L-1:0] v_rdata;
   logic [A-1:0]      mem_addr;
   logic [L-1:0]      mem_wdata;
   logic              mem_wren;
   logic [L-1:0]      mem_rdata;
`ifdef VSEQ_STRIDE_EN
   logic [15:0]       v_stride;
`endif

   vector_mem_sequencer #(.L(L), .LANES(LANES), .A(A)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .s_req_i     (s_req),
      .s_we_i      (s_we),
      .s_addr_i    (s_addr),
      .s_wdata_i   (s_wdata),
      .s_ack_o     (s_ack),
      .s_rdata_o   (s_rdata),
      .v_req_i     (v_req),
      .v_we_i      (v_we),
      .v_addr_i    (v_addr),
`ifdef VSEQ_STRIDE_EN
      .v_stride_i  (v_stride),
`endif
      .v_wdata_i   (v_wdata),
      .v_done_o    (v_done),
      .v_busy_o    (v_busy),
      .v_rdata_o   (v_rdata),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_wren_o  (mem_wren),
      .mem_rdata_i (mem_rdata)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Memory model: 256 bytes aliased on address bits [7:0], same-cycle read.
   logic [7:0] mem [0:255];
   logic       mem_fill;

   function automatic logic [7:0] init_val(input int i);
      if (i == 16) return 8'h5A;
      return 8'(i) ^ 8'hC3;
   endfunction

   always @(posedge CLK) begin
      if (mem_fill) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      end else if (mem_wren) begin
         mem[mem_addr[7:0]] <= mem_wdata;
      end
   end
   assign mem_rdata = mem[mem_addr[7:0]];

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard of expected memory-port cycles, popped by the monitor.
   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  wdata;
      logic        wren;
   } acc_t;

   acc_t exp_q[$];
   int   busy_cnt = 0;
   int   done_cnt = 0;

   always @(negedge CLK) begin
      acc_t e;
      if (v_busy) busy_cnt++;
      if (v_done) done_cnt++;
      if (RST && (v_busy || mem_wren || (mem_addr != '0))) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_access: got addr %0h wdata %0h wren %0b expected no access",
                     mem_addr, mem_wdata, mem_wren);
         end else begin
            e = exp_q.pop_front();
            check("mem_access", 128'({mem_addr, mem_wdata, mem_wren}), 128'(e));
         end
      end
   end

   task automatic push_expect(input logic is_vec, input logic we, input logic [31:0] addr,
                              input logic [63:0] wd, input logic [31:0] stride);
      acc_t e;
      if (!is_vec) begin
         e.addr = addr; e.wdata = wd[7:0]; e.wren = we;
         exp_q.push_back(e);
      end else begin
         for (int i = 0; i < LANES; i++) begin
            e.addr  = addr + 32'(i) * stride;
            e.wdata = wd[i*8 +: 8];
            e.wren  = we;
            exp_q.push_back(e);
         end
      end
   endtask

   typedef struct {
      logic        is_vec;
      logic        we;
      logic [31:0] addr;
      logic [63:0] wdata;
      logic [15:0] stride;
      logic [7:0]  exp_s;
      logic [63:0] exp_v;
   } txn_t;

   task automatic run_txn(input txn_t t);
      int          got;
      logic [31:0] stride32;
`ifdef VSEQ_STRIDE_EN
      stride32 = {{16{t.stride[15]}}, t.stride};
`else
      stride32 = 32'd1;
`endif
      @(negedge CLK);
      if (t.is_vec) begin
         v_req = 1'b1; v_we = t.we; v_addr = t.addr; v_wdata = t.wdata;
`ifdef VSEQ_STRIDE_EN
         v_stride = t.stride;
`endif
      end else begin
         s_req = 1'b1; s_we = t.we; s_addr = t.addr; s_wdata = t.wdata[7:0];
      end
      push_expect(t.is_vec, t.we, t.addr, t.wdata, stride32);
      busy_cnt = 0;
      got = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge CLK);
         if (t.is_vec ? v_done : s_ack) begin
            got = c;
            break;
         end
      end
      s_req = 1'b0;
      v_req = 1'b0;
      check("latency", 128'(got), t.is_vec ? 128'(LANES + 1) : 128'(2));
      check("s_rdata", 128'(s_rdata), 128'(t.exp_s));
      check("v_rdata", 128'(v_rdata), 128'(t.exp_v));
      check("busy_cycles", 128'(busy_cnt), t.is_vec ? 128'(LANES) : 128'(0));
      @(negedge CLK);
      check("pulse_width", 128'({s_ack, v_done}), 128'(0));
   endtask

   task automatic check_all_zero(input string name);
      check(name, 128'({s_ack, s_rdata, v_done, v_busy, mem_addr, mem_wdata, mem_wren}), 128'(0));
      check({name, "_vrdata"}, 128'(v_rdata), 128'(0));
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      check_all_zero("reset_outputs");
      RST = 1'b1;
   endtask

   txn_t tbl [9];

   initial begin
      #300000;
      $display("FAIL watchdog: got no completion expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] ev_bits;
      int          n_ev;
      int          done_before;
      logic [63:0] ev64;
      txn_t        t;

      tbl[0] = '{1'b0, 1'b0, 32'h0001_0010, 64'h0, 16'h0001, 8'h5A, 64'h0};
      tbl[1] = '{1'b1, 1'b1, 32'h0002_0000, 64'h0706_0504_0302_0100, 16'h0001, 8'h5A, 64'h0};
      tbl[2] = '{1'b1, 1'b0, 32'h0002_0000, 64'h0, 16'h0001, 8'h5A, 64'h0706_0504_0302_0100};
      tbl[3] = '{1'b0, 1'b1, 32'h0000_0040, 64'h99, 16'h0001, 8'h5A, 64'h0706_0504_0302_0100};
      tbl[4] = '{1'b0, 1'b0, 32'h0000_0040, 64'h0, 16'h0001, 8'h99, 64'h0706_0504_0302_0100};
      tbl[5] = '{1'b1, 1'b0, 32'h0000_00FC, 64'h0, 16'h0001, 8'h99, 64'h0302_0100_3C3D_3E3F};
      tbl[6] = '{1'b1, 1'b1, 32'hFFFF_FFFE, 64'h1122_3344_5566_7788, 16'h0001, 8'h99,
                 64'h0302_0100_3C3D_3E3F};
      tbl[7] = '{1'b0, 1'b0, 32'h0000_0003, 64'h0, 16'h0001, 8'h33, 64'h0302_0100_3C3D_3E3F};
      tbl[8] = '{1'b0, 1'b0, 32'h0000_00FE, 64'h0, 16'h0001, 8'h88, 64'h0302_0100_3C3D_3E3F};

      RST = 1'b0; mem_fill = 1'b1;
      s_req = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0;
      v_req = 1'b0; v_we = 1'b0; v_addr = '0; v_wdata = '0;
`ifdef VSEQ_STRIDE_EN
      v_stride = 16'h0001;
`endif
      repeat (2) @(negedge CLK);
      mem_fill = 1'b0;
      check_all_zero("reset_outputs");
      RST = 1'b1;

      for (int i = 0; i < 9; i++) run_txn(tbl[i]);

      // Simultaneous requests straight out of reset: scalar first, then alternation.
      do_reset();
      @(negedge CLK);
      s_req = 1'b1; s_we = 1'b0; s_addr = 32'h0000_0010; s_wdata = '0;
      v_req = 1'b1; v_we = 1'b0; v_addr = 32'h0002_0000; v_wdata = '0;
`ifdef VSEQ_STRIDE_EN
      v_stride = 16'h0001;
`endif
      push_expect(1'b0, 1'b0, 32'h0000_0010, 64'h0, 32'd1);
      push_expect(1'b1, 1'b0, 32'h0002_0000, 64'h0, 32'd1);
      push_expect(1'b0, 1'b0, 32'h0000_0010, 64'h0, 32'd1);
      push_expect(1'b1, 1'b0, 32'h0002_0000, 64'h0, 32'd1);
      busy_cnt = 0;
      ev_bits = '0;
      n_ev = 0;
      for (int c = 0; c < 200 && n_ev < 4; c++) begin
         @(negedge CLK);
         if (s_ack) begin ev_bits = {ev_bits[23:0], 8'h53}; n_ev++; end
         if (v_done) begin ev_bits = {ev_bits[23:0], 8'h56}; n_ev++; end
      end
      s_req = 1'b0;
      v_req = 1'b0;
      check("rr_order", 128'(ev_bits), 128'(32'h5356_5356));
      check("rr_busy_cycles", 128'(busy_cnt), 128'(2 * LANES));
      check("rr_s_rdata", 128'(s_rdata), 128'(8'h5A));
      check("rr_v_rdata", 128'(v_rdata), 128'(64'h0706_1122_3344_5566));
      repeat (2) @(negedge CLK);

      // Reset asserted during lane 3 of a vector write.
      @(negedge CLK);
      v_req = 1'b1; v_we = 1'b1; v_addr = 32'h0000_0080; v_wdata = 64'hA7A6_A5A4_A3A2_A1A0;
      for (int i = 0; i < 3; i++) begin
         acc_t e;
         e.addr = 32'h80 + 32'(i); e.wdata = 8'hA0 + 8'(i); e.wren = 1'b1;
         exp_q.push_back(e);
      end
      done_before = done_cnt;
      @(posedge CLK);
      repeat (3) @(posedge CLK);
      #2;
      RST = 1'b0;
      v_req = 1'b0;
      #1;
      check("abort_wren", 128'(mem_wren), 128'(0));
      check_all_zero("abort_outputs");
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      repeat (4) @(negedge CLK);
      check("abort_no_done", 128'(done_cnt), 128'(done_before));
      check("abort_queue_drained", 128'(exp_q.size()), 128'(0));
      for (int i = 0; i < 8; i++) begin
         check("abort_mem", 128'(mem[8'h80 + 8'(i)]),
               (i < 3) ? 128'(8'hA0 + 8'(i)) : 128'(init_val(8'h80 + i)));
      end
      t = '{1'b1, 1'b0, 32'h0000_0080, 64'h0, 16'h0001, 8'h00, 64'h4445_4647_40A2_A1A0};
      run_txn(t);

`ifdef VSEQ_STRIDE_EN
      // Negative stride wraps below zero.
      for (int i = 0; i < LANES; i++) ev64[i*8 +: 8] = mem[8'(32'd1 - 32'(i))];
      t = '{1'b1, 1'b0, 32'h0000_0001, 64'h0, 16'hFFFF, 8'h00, ev64};
      run_txn(t);
`else
      ev64 = '0;
`endif

      repeat (2) @(negedge CLK);
      check("final_queue_empty", 128'(exp_q.size()), 128'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
